branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/brp_pkg.sv | 38 +++
 rtl/br_resolve.sv | 43 ++++
 rtl/branch_predictor.sv | 129 ++++++++++++
 3 files changed

// File: rtl/brp_pkg.sv
// Shared definitions for the branch predictor slice.
//   - IDX_W_DEF   : default table index width
//   - cnt_state_e : two-bit saturating counter states SNT/WNT/WT/ST
//   - F3_*        : conditional branch funct3 encodings (BEQ..BGEU)
//   - cnt_next()  : counter transition for one resolved branch
package brp_pkg;

  localparam int IDX_W_DEF = 6;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_state_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Taken moves toward ST, not-taken toward SNT; both ends saturate.
  function automatic cnt_state_e cnt_next(input cnt_state_e cur, input logic taken);
    cnt_state_e nxt;
    nxt = cur;
    case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/br_resolve.sv
// Combinational branch resolution.
// Ports:
//   i_upd_valid   : a resolved branch is presented
//   i_funct3      : branch funct3
//   i_pred_taken  : direction that was predicted
//   i_less/i_equal: comparator flags
//   o_br_un       : comparator mode (0 signed, 1 unsigned) = funct3[1]
//   o_taken       : resolved direction (0 for illegal funct3)
//   o_legal       : funct3 is one of the six conditional branches
//   o_mispredict  : valid, legal and direction differs from prediction
module br_resolve
  import brp_pkg::*;
(
  input  logic       i_upd_valid,
  input  logic [2:0] i_funct3,
  input  logic       i_pred_taken,
  input  logic       i_less,
  input  logic       i_equal,
  output logic       o_br_un,
  output logic       o_taken,
  output logic       o_legal,
  output logic       o_mispredict
);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    o_taken = 1'b0;
    o_legal = 1'b1;
    case (i_funct3)
      F3_BEQ:  o_taken = i_equal;
      F3_BNE:  o_taken = ~i_equal;
      F3_BLT:  o_taken = i_less;
      F3_BGE:  o_taken = ~i_less;
      F3_BLTU: o_taken = i_less;
      F3_BGEU: o_taken = ~i_less;
      default: o_legal = 1'b0;
    endcase
  end

  assign o_br_un      = i_funct3[1];
  assign o_mispredict = i_upd_valid & o_legal & (o_taken != i_pred_taken);

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2^IDX_W two-bit saturating counters indexed by
// pc[IDX_W+1:2]. One registered lookup and one update per cycle; a lookup
// colliding with an update in the same cycle sees the pre-update counter.
// Ports:
//   i_clk, i_rst_n                      : clock, async active-low reset
//   i_pred_valid, i_pred_pc             : lookup request
//   o_pred_valid, o_pred_taken          : registered prediction (latency 1)
//   i_upd_valid, i_upd_pc, i_upd_funct3 : resolved branch
//   i_upd_pred_taken, i_br_less/equal   : predicted direction, comparator flags
//   o_br_un, o_upd_taken, o_mispredict  : combinational resolution
//   o_br_cnt, o_miss_cnt                : performance counters
// Configuration: define BRP_PERF_EN to build the performance counters;
// otherwise they read as zero and no counter registers exist.
module branch_predictor
  import brp_pkg::*;
#(
  parameter int         IDX_W    = IDX_W_DEF,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pred_valid,
  input  logic [31:0] i_pred_pc,
  output logic        o_pred_valid,
  output logic        o_pred_taken,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic [2:0]  i_upd_funct3,
  input  logic        i_upd_pred_taken,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  output logic        o_br_un,
  output logic        o_upd_taken,
  output logic        o_mispredict,
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_miss_cnt
);

  localparam int DEPTH = 1 << IDX_W;

  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_legal;
  logic             upd_en;

  cnt_state_e table_q [DEPTH];
  cnt_state_e table_d [DEPTH];
  logic       pred_valid_q, pred_valid_d;
  logic       pred_taken_q, pred_taken_d;

  // Byte offset and high PC bits do not take part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_pred_pc[31:IDX_W+2], i_pred_pc[1:0],
                            i_upd_pc[31:IDX_W+2], i_upd_pc[1:0]};

  assign pred_idx = i_pred_pc[IDX_W+1:2];
  assign upd_idx  = i_upd_pc[IDX_W+1:2];

  br_resolve u_resolve (
    .i_upd_valid  (i_upd_valid),
    .i_funct3     (i_upd_funct3),
    .i_pred_taken (i_upd_pred_taken),
    .i_less       (i_br_less),
    .i_equal      (i_br_equal),
    .o_br_un      (o_br_un),
    .o_taken      (o_upd_taken),
    .o_legal      (upd_legal),
    .o_mispredict (o_mispredict)
  );

  // Illegal funct3 leaves the table untouched.
  assign upd_en = i_upd_valid & upd_legal;

  always_comb begin
    table_d = table_q;
    if (upd_en) table_d[upd_idx] = cnt_next(table_q[upd_idx], o_upd_taken);
  end

  // Reading table_q (not table_d) gives read-before-write on a collision.
  always_comb begin
    pred_valid_d = i_pred_valid;
    pred_taken_d = i_pred_valid & (table_q[pred_idx] inside {WT, ST});
  end

  // NOTE: the counter table is reset in full because every entry must start at CNT_INIT; a reset-less RAM is not an option here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= cnt_state_e'(CNT_INIT);
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
      table_q      <= table_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
    end
  end

  assign o_pred_valid = pred_valid_q;
  assign o_pred_taken = pred_taken_q;

`ifdef BRP_PERF_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Both counters wrap naturally at 32 bits.
  always_comb begin
    br_cnt_d   = br_cnt_q + {31'd0, upd_en};
    miss_cnt_d = miss_cnt_q + {31'd0, o_mispredict};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign o_br_cnt   = br_cnt_q;
  assign o_miss_cnt = miss_cnt_q;
`else
  assign o_br_cnt   = '0;
  assign o_miss_cnt = '0;
`endif

endmodule
